// File: rtl/vproc_pkg.sv
// vproc_pkg: shared vector-register write types and constants
package vproc_pkg;

    localparam int VREG_CNT    = 32;
    localparam int VREG_ADDR_W = 5;
    localparam int VREG_PORT_W = 128;

    typedef struct packed {
        logic [VREG_ADDR_W-1:0]   addr;
        logic [VREG_PORT_W-1:0]   data;
        logic [VREG_PORT_W/8-1:0] be;
    } vreg_wr_req_t;

endpackage

// File: rtl/vproc_rr_grant.sv
// vproc_rr_grant: combinational multi-grant round-robin selector with same-address conflict handling
module vproc_rr_grant #(
    parameter int REQ_CNT  = 5,
    parameter int PORT_CNT = 2,
    parameter int PTR_W    = 3,
    parameter int PIDX_W   = 1
) (
    input  logic [REQ_CNT-1:0]              req_i,
    input  logic [REQ_CNT-1:0][REQ_CNT-1:0] conflict_i,
    input  logic [REQ_CNT-1:0][REQ_CNT-1:0] overlap_i,
    input  logic [PTR_W-1:0]                ptr_i,
    output logic [REQ_CNT-1:0]              gnt_o,
    output logic [REQ_CNT-1:0][PIDX_W-1:0]  port_o,
    output logic [PTR_W-1:0]                nxt_o
);

    int                idx;
    int                used;
    logic              same;
    logic              ovl;
    logic [PIDX_W-1:0] prt;

    // A request joining an already-granted address shares that grant's port, unless enables overlap
    always_comb begin
        gnt_o  = '0;
        port_o = '0;
        nxt_o  = ptr_i;
        used   = 0;
        idx    = 0;
        same   = 1'b0;
        ovl    = 1'b0;
        prt    = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            idx  = (int'(ptr_i) + k) % REQ_CNT;
            same = 1'b0;
            ovl  = 1'b0;
            prt  = '0;
            for (int j = 0; j < REQ_CNT; j++) begin
                if (gnt_o[j] && conflict_i[idx][j]) begin
                    same = 1'b1;
                    ovl  = ovl | overlap_i[idx][j];
                    prt  = port_o[j];
                end
            end
            if (req_i[idx] && (same ? !ovl : (used < PORT_CNT))) begin
                gnt_o[idx]  = 1'b1;
                port_o[idx] = same ? prt : PIDX_W'(used);
                used        = same ? used : used + 1;
                nxt_o       = PTR_W'((idx + 1) % REQ_CNT);
            end
        end
    end

endmodule

// File: rtl/vproc_vreg_wr_arbiter.sv
// vproc_vreg_wr_arbiter: round-robin register-file write-port arbiter; VPROC_VREG_WRARB_MERGE_EN enables same-address byte merging
module vproc_vreg_wr_arbiter
    import vproc_pkg::*;
#(
    parameter int REQ_CNT     = 5,
    parameter int PORT_WR_CNT = 2,
    parameter int PORT_W      = 128,
    parameter int ADDR_W      = 5
) (
    input  logic                                   clk_i,
    input  logic                                   sync_rst_ni,
    input  logic [REQ_CNT-1:0]                     req_valid_i,
    output logic [REQ_CNT-1:0]                     req_ready_o,
    input  logic [REQ_CNT-1:0][ADDR_W-1:0]         req_addr_i,
    input  logic [REQ_CNT-1:0][PORT_W-1:0]         req_data_i,
    input  logic [REQ_CNT-1:0][PORT_W/8-1:0]       req_be_i,
    output logic [PORT_WR_CNT-1:0]                 wr_we_o,
    output logic [PORT_WR_CNT-1:0][ADDR_W-1:0]     wr_addr_o,
    output logic [PORT_WR_CNT-1:0][PORT_W-1:0]     wr_data_o,
    output logic [PORT_WR_CNT-1:0][PORT_W/8-1:0]   wr_be_o,
    output logic [VREG_CNT-1:0]                    wr_pend_o
);

    localparam int PTR_W  = REQ_CNT > 1 ? $clog2(REQ_CNT) : 1;
    localparam int PIDX_W = PORT_WR_CNT > 1 ? $clog2(PORT_WR_CNT) : 1;
    localparam int BE_W   = PORT_W / 8;

    logic [PTR_W-1:0]                   rr_q, rr_d;
    logic [PORT_WR_CNT-1:0]             we_q, we_d;
    logic [PORT_WR_CNT-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [PORT_WR_CNT-1:0][PORT_W-1:0] data_q, data_d;
    logic [PORT_WR_CNT-1:0][BE_W-1:0]   be_q, be_d;

    logic [REQ_CNT-1:0][REQ_CNT-1:0]    conflict, overlap;
    logic [REQ_CNT-1:0]                 gnt;
    logic [REQ_CNT-1:0][PIDX_W-1:0]     gnt_port;
`ifdef VPROC_VREG_WRARB_MERGE_EN
    logic [PORT_WR_CNT-1:0][PORT_W-1:0] fill;
`endif

    // Without merging, every same-address pair counts as overlapping and therefore serializes
    always_comb begin
        conflict = '0;
        overlap  = '1;
        for (int i = 0; i < REQ_CNT; i++) begin
            for (int j = 0; j < REQ_CNT; j++) begin
                conflict[i][j] = req_addr_i[i] == req_addr_i[j];
`ifdef VPROC_VREG_WRARB_MERGE_EN
                overlap[i][j] = |(req_be_i[i] & req_be_i[j]);
`endif
            end
        end
    end

    vproc_rr_grant #(
        .REQ_CNT  (REQ_CNT),
        .PORT_CNT (PORT_WR_CNT),
        .PTR_W    (PTR_W),
        .PIDX_W   (PIDX_W)
    ) u_grant (
        .req_i      (req_valid_i),
        .conflict_i (conflict),
        .overlap_i  (overlap),
        .ptr_i      (rr_q),
        .gnt_o      (gnt),
        .port_o     (gnt_port),
        .nxt_o      (rr_d)
    );

    assign req_ready_o = gnt & {REQ_CNT{sync_rst_ni}};

    always_comb begin
        we_d   = '0;
        addr_d = '0;
        data_d = '0;
        be_d   = '0;
`ifdef VPROC_VREG_WRARB_MERGE_EN
        fill   = '0;
`endif
        for (int p = 0; p < PORT_WR_CNT; p++) begin
            for (int r = 0; r < REQ_CNT; r++) begin
                if (gnt[r] && gnt_port[r] == PIDX_W'(p)) begin
                    we_d[p]   = 1'b1;
                    addr_d[p] = addr_d[p] | req_addr_i[r];
                    be_d[p]   = be_d[p] | req_be_i[r];
`ifdef VPROC_VREG_WRARB_MERGE_EN
                    fill[p]   = fill[p] | req_data_i[r];
                    for (int b = 0; b < BE_W; b++) begin
                        data_d[p][8*b +: 8] = data_d[p][8*b +: 8] | (req_be_i[r][b] ? req_data_i[r][8*b +: 8] : 8'h00);
                    end
`else
                    data_d[p] = data_d[p] | req_data_i[r];
`endif
                end
            end
`ifdef VPROC_VREG_WRARB_MERGE_EN
            // Disabled bytes carry through whatever the group supplied so a lone write keeps its data
            for (int b = 0; b < BE_W; b++) begin
                data_d[p][8*b +: 8] = be_d[p][b] ? data_d[p][8*b +: 8] : fill[p][8*b +: 8];
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            rr_q   <= '0;
            we_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else begin
            rr_q   <= rr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            be_q   <= be_d;
        end
    end

    assign wr_we_o   = we_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
    assign wr_be_o   = be_q;

    always_comb begin
        wr_pend_o = '0;
        for (int p = 0; p < PORT_WR_CNT; p++) begin
            if (we_q[p]) wr_pend_o[addr_q[p]] = 1'b1;
        end
    end

endmodule
